// File: rtl/fetch_next_pc.sv
// fetch_next_pc: fetch-stage front end in front of the 32-bit PC register.
// It computes the value the PC register loads each cycle (pc_next), issues
// one word read at a time to instruction memory over a req/ack handshake,
// and buffers returned words, each tagged with its PC, in a DEPTH-entry FIFO
// for decode. A redirect flushes the buffer and discards any response that
// is still in flight.
// Optional build macro FETCH_PERF_CNT_EN adds the stall_cnt and drop_cnt
// performance counters. They are absent when the macro is undefined.
module fetch_next_pc #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [15:0] drop_cnt
`endif
);

  // IDLE: nothing outstanding. WAIT: response will be kept.
  // DROP: response belongs to a flushed path and will be thrown away.
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fq_entry_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  state_t          r_state;
  logic            r_imem_req;
  logic [31:0]     r_imem_addr;
  logic [31:0]     r_req_pc;
  logic [PTR_W:0]  r_count;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  fq_entry_t       r_fifo [DEPTH];

  logic            w_full;
  logic            w_launch;
  logic            w_push;
  logic            w_pop;
  logic [31:0]     w_pc_align;
  logic [31:0]     w_pc_inc;

  assign w_full     = (r_count == FULL_CNT);
  assign w_pc_align = {pc_cur[31:2], 2'b00};
  // Plain 32-bit add, so 0xFFFFFFFC wraps to 0.
  assign w_pc_inc   = w_pc_align + 32'd4;

  // A launch reserves a FIFO slot up front: count can only fall before the
  // response returns, so the push can never overflow.
  assign w_launch = (r_state == IDLE) && !redirect && !w_full;
  // Redirect kills both sides of the FIFO in the same cycle.
  assign w_push   = (r_state == WAIT) && imem_ack && !redirect;
  assign w_pop    = (r_count != '0) && inst_ready && !redirect;

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_imem_addr;
  assign inst_valid = (r_count != '0);
  assign inst_data  = r_fifo[r_rptr].inst;
  assign inst_pc    = r_fifo[r_rptr].pc;

  // Next PC: reset forces 0, redirect wins, a launch steps one word, else hold.
  always_comb begin
    pc_next = pc_cur;
    if (rst)
      pc_next = '0;
    else if (redirect)
      pc_next = redirect_pc;
    else if (w_launch)
      pc_next = w_pc_inc;
  end

  // Request FSM with registered req/addr and the PC of the outstanding read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_imem_req  <= 1'b0;
      r_imem_addr <= '0;
      r_req_pc    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          // A stray ack here is a protocol error and is ignored.
          if (w_launch) begin
            r_imem_req  <= 1'b1;
            r_imem_addr <= w_pc_align;
            r_req_pc    <= pc_cur;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          // An ack always ends the request; redirect only decides whether
          // the data is kept, and that is handled by w_push.
          if (imem_ack) begin
            r_imem_req <= 1'b0;
            r_state    <= IDLE;
          end else if (redirect) begin
            r_state <= DROP;
          end
        end
        DROP: begin
          if (imem_ack) begin
            r_imem_req <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_imem_req <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  // FIFO occupancy and pointers; redirect flushes like a reset.
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)
        r_rptr <= r_rptr + PTR_W'(1);
      if (w_push && !w_pop)
        r_count <= r_count + (PTR_W+1)'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - (PTR_W+1)'(1);
    end
  end

  // FIFO storage; contents are only meaningful where count says so.
  always_ff @(posedge clk) begin
    if (w_push)
      r_fifo[r_wptr] <= '{inst: imem_rdata, pc: r_req_pc};
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [15:0] r_drop_cnt;

  assign stall_cnt = r_stall_cnt;
  assign drop_cnt  = r_drop_cnt;

  // Count cycles where fetch sits idle only because the buffer is full.
  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= '0;
    else if ((r_state == IDLE) && !redirect && w_full && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  // Count responses thrown away because their path was redirected.
  always_ff @(posedge clk) begin
    if (rst)
      r_drop_cnt <= '0;
    else if ((r_state == DROP) && imem_ack && (r_drop_cnt != '1))
      r_drop_cnt <= r_drop_cnt + 16'd1;
  end
`endif

  // The slot reservation at launch must keep a push from landing on a full
  // buffer unless a pop frees a slot in the same cycle.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && w_full));

endmodule

// File: tb/tb_fetch_next_pc.sv
// tb_fetch_next_pc: scoreboard bench for fetch_next_pc. The bench acts as the
// PC register and the instruction memory; expected {inst, pc} pairs are
// queued when stimulus is applied and compared as decode pops them.
module tb_fetch_next_pc;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_cur = '0;
  logic [31:0] pc_next;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [15:0] drop_cnt;
`endif

  int   n_chk  = 0;
  int   n_pass = 0;
  int   mem_lat = 0;
  logic inj_ack = 1'b0;
  exp_t q[$];

  fetch_next_pc #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_next(pc_next),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Bench-side PC register.
  always @(posedge clk) pc_cur <= pc_next;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask

  task automatic expect_word(input logic [31:0] pc);
    q.push_back('{inst: mem_word({pc[31:2], 2'b00}), pc: pc});
  endtask

  // Memory: acks mem_lat cycles after req is first seen, or once on inj_ack.
  initial begin
    int wcnt = 0;
    forever begin
      @(posedge clk); #1;
      imem_ack = 1'b0;
      if (inj_ack) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
      end else if (rst || !imem_req) begin
        wcnt = 0;
      end else if (wcnt >= mem_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end
  end

  // Scoreboard consumer: every accepted head must match the queue front.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && !redirect && inst_valid && inst_ready) begin
        chk("pop_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          chk("pop_pc", inst_pc, e.pc);
          chk("pop_inst", inst_data, e.inst);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Entered and left at posedge+1; leaves the bench at cycle c0 after release.
  task automatic do_reset(input int lat, input logic rdy);
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    inst_ready = rdy; mem_lat = lat; inj_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_pc_next", pc_next, 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Wait for the scoreboard to empty, then stop accepting.
  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
    inst_ready = 1'b0;
  endtask

  initial begin
    // 1: streaming fetch from reset.
    do_reset(1, 1'b1);
    expect_word(32'h0); expect_word(32'h4);
    expect_word(32'h8); expect_word(32'hC);
    drain(60);

    // 2: fill the buffer with decode stalled, then resume.
    do_reset(0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_req", 32'(imem_req), 32'd0);
      chk("full_pc_next", pc_next, 32'h10);
      chk("full_valid", 32'(inst_valid), 32'd1);
      @(posedge clk); #1;
    end
`ifdef FETCH_PERF_CNT_EN
    @(negedge clk);
    chk("stall_cnt", stall_cnt, 32'd6);
    @(posedge clk); #1;
`endif
    inst_ready = 1'b1;
    expect_word(32'h0); expect_word(32'h4); expect_word(32'h8);
    expect_word(32'hC); expect_word(32'h10);
    drain(60);

    // 3: redirect while WAIT; the late response must be dropped.
    do_reset(3, 1'b1);
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h1000;
    @(negedge clk);
    chk("t3_pc_next", pc_next, 32'h1000);
    @(posedge clk); #1;
    redirect = 1'b0;
    expect_word(32'h1000);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t3_valid_low", 32'(inst_valid), 32'd0);
      if (i == 0) chk("t3_req_held", 32'(imem_req), 32'd1);
      @(posedge clk); #1;
    end
    drain(60);
`ifdef FETCH_PERF_CNT_EN
    @(negedge clk);
    chk("drop_cnt", 32'(drop_cnt), 32'd1);
    @(posedge clk); #1;
`endif

    // 4: redirect coinciding with an ack and a pop at count=2.
    do_reset(0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    redirect = 1'b1; redirect_pc = 32'h2000; inst_ready = 1'b1;
    @(negedge clk);
    chk("t4_ack_aligned", 32'(imem_ack), 32'd1);
    chk("t4_valid_pre", 32'(inst_valid), 32'd1);
    chk("t4_pc_next", pc_next, 32'h2000);
    @(posedge clk); #1;
    redirect = 1'b0;
    expect_word(32'h2000);
    @(negedge clk);
    chk("t4_flushed", 32'(inst_valid), 32'd0);
    chk("t4_req_low", 32'(imem_req), 32'd0);
    chk("t4_idle_launch", pc_next, 32'h2004);
    drain(60);

    // 5a: launch from the top word wraps pc_next to 0.
    do_reset(0, 1'b1);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("t5_wrap", pc_next, 32'h0);
    expect_word(32'hFFFF_FFFC);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    chk("t5_req_top", 32'(imem_req), 32'd1);
    drain(60);

    // 5b: misaligned pc_cur.
    do_reset(0, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h6;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("t5_misalign_next", pc_next, 32'h8);
    expect_word(32'h6);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_misalign_addr", imem_addr, 32'h4);
    drain(60);

    // 6: reset mid-request, then a stray ack while idle.
    do_reset(3, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_req_low", 32'(imem_req), 32'd0);
    chk("t6_valid_low", 32'(inst_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("t6_stall_cnt", stall_cnt, 32'd0);
    chk("t6_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    inj_ack = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    inj_ack = 1'b0;
    @(negedge clk);
    chk("t6_stray_ack", 32'(imem_ack), 32'd1);
    chk("t6_idle_req", 32'(imem_req), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_no_push", 32'(inst_valid), 32'd0);
    chk("t6_launch", 32'(imem_req), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_no_push2", 32'(inst_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
